// File: rtl/load_store_unit_pkg.sv
// Shared widths for the LSU slice: cache alignment constants and LSU FSM types.
package basic_cache_params;
  localparam int unsigned XLEN              = 64;
  localparam int unsigned paddr_size        = 32;
  localparam int unsigned offset_bits       = $clog2(XLEN / 8);
  localparam int unsigned aligned_addr_size = paddr_size - offset_bits;
endpackage

package lsu_types;
  import basic_cache_params::*;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } lsu_state_e;

  // One extra bit so base+size cannot wrap during the range check.
  localparam int unsigned RANGE_W = aligned_addr_size + 1;

  function automatic logic addr_in_range(input logic [RANGE_W-1:0] addr,
                                         input logic [RANGE_W-1:0] base,
                                         input logic [RANGE_W-1:0] size);
    logic [RANGE_W-1:0] limit;
    limit = base + size;
    return (addr >= base) && (addr < limit);
  endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// LSU request/completion port plus the data-cache request/response port.
interface load_store_unit_if;
  import basic_cache_params::*;

  logic                         lsu_prev_stalled;
  logic                         lsu_stall_next;
  logic [aligned_addr_size-1:0] lsu_addr;
  logic                         lsu_do_load;
  logic                         lsu_do_store;
  logic [XLEN-1:0]              lsu_store_data;
  logic [XLEN/8-1:0]            lsu_store_mask;
  logic [XLEN-1:0]              lsu_load_data;
  logic                         lsu_access_fault;
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic [aligned_addr_size-1:0] mem_req_addr;
  logic                         mem_req_write;
  logic [XLEN-1:0]              mem_req_wdata;
  logic [XLEN/8-1:0]            mem_req_wmask;
  logic                         mem_resp_valid;
  logic [XLEN-1:0]              mem_resp_data;
  logic                         mem_resp_error;

  modport slave (
    input  lsu_prev_stalled, lsu_addr, lsu_do_load, lsu_do_store,
           lsu_store_data, lsu_store_mask,
           mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
    output lsu_stall_next, lsu_load_data, lsu_access_fault,
           mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output lsu_prev_stalled, lsu_addr, lsu_do_load, lsu_do_store,
           lsu_store_data, lsu_store_mask,
           mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_error,
    input  lsu_stall_next, lsu_load_data, lsu_access_fault,
           mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/load_store_unit_watchdog.sv
// Response watchdog (module lsu_watchdog): WAIT-cycle counter and stale-response drop flag.
module lsu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait_i,
  input  logic wait_enter_i,
  input  logic resp_valid_i,
  output logic resp_ok_o,
  output logic timeout_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;

  assign resp_ok_o = resp_valid_i && !drop_q;
  assign timeout_o = in_wait_i && !resp_ok_o && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    drop_d = drop_q;
    if (wait_enter_i) begin
      cnt_d = '0;
    end else if (in_wait_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    // A timeout leaves a response in flight, so arm the drop even if a stale one lands now.
    if (timeout_o) begin
      drop_d = 1'b1;
    end else if (resp_valid_i) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// Execute-stage LSU responder: range-checks one aligned dword access and forwards it to the cache.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import basic_cache_params::*, lsu_types::*;
#(
  parameter logic [aligned_addr_size-1:0] MEM_BASE       = 'h0,
  parameter logic [aligned_addr_size:0]   MEM_SIZE       = 'h10000,
  parameter int unsigned                  TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  lsu_state_e                   state_q, state_d;
  logic [aligned_addr_size-1:0] addr_q, addr_d;
  logic [XLEN-1:0]              wdata_q, wdata_d;
  logic [XLEN/8-1:0]            wmask_q, wmask_d;
  logic                         write_q, write_d;
  logic [XLEN-1:0]              load_data_q, load_data_d;
  logic                         fault_q, fault_d;

  logic accept;
  logic in_range;
  logic resp_ok;
  logic timeout;

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && !bus.lsu_prev_stalled;
  assign in_range = addr_in_range({1'b0, bus.lsu_addr}, {1'b0, MEM_BASE}, MEM_SIZE);

`ifdef LSU_TIMEOUT_EN
  logic in_wait;
  logic wait_enter;

  assign in_wait    = (state_q == WAIT);
  assign wait_enter = (state_q == REQ) && bus.mem_req_ready;

  lsu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .in_wait_i    (in_wait),
    .wait_enter_i (wait_enter),
    .resp_valid_i (bus.mem_resp_valid),
    .resp_ok_o    (resp_ok),
    .timeout_o    (timeout)
  );
`else
  assign resp_ok = bus.mem_resp_valid;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    write_d     = write_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          addr_d  = bus.lsu_addr;
          wdata_d = bus.lsu_store_data;
          wmask_d = bus.lsu_store_mask;
          // Neither or both strobes fall back to a load.
          write_d = bus.lsu_do_store && !bus.lsu_do_load;
          if (in_range) begin
            state_d = REQ;
          end else begin
            state_d     = DONE;
            load_data_d = '0;
            fault_d     = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (resp_ok) begin
          state_d     = DONE;
          load_data_d = write_q ? '0 : bus.mem_resp_data;
          fault_d     = bus.mem_resp_error;
        end else if (timeout) begin
          state_d     = DONE;
          load_data_d = '0;
          fault_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      write_q     <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      write_q     <= write_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.lsu_stall_next   = (state_q != DONE);
  assign bus.lsu_load_data    = load_data_q;
  assign bus.lsu_access_fault = fault_q;
  assign bus.mem_req_valid    = (state_q == REQ);
  assign bus.mem_req_addr     = addr_q;
  assign bus.mem_req_write    = write_q;
  assign bus.mem_req_wdata    = wdata_q;
  assign bus.mem_req_wmask    = wmask_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; the watchdog section runs only when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
  import basic_cache_params::*;

  localparam logic [aligned_addr_size-1:0] BASE = 'h100;
  localparam logic [aligned_addr_size:0]   SIZE = 'h40;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(
    .MEM_BASE      (BASE),
    .MEM_SIZE      (SIZE),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [aligned_addr_size-1:0] a, input logic ld, input logic st);
    bus.lsu_prev_stalled = 1'b0;
    bus.lsu_addr         = a;
    bus.lsu_do_load      = ld;
    bus.lsu_do_store     = st;
  endtask

  task automatic cache(input logic rdy, input logic rv, input logic [63:0] d, input logic err);
    bus.mem_req_ready  = rdy;
    bus.mem_resp_valid = rv;
    bus.mem_resp_data  = d;
    bus.mem_resp_error = err;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst                  = 1'b1;
    bus.lsu_prev_stalled = 1'b1;
    bus.lsu_addr         = '0;
    bus.lsu_do_load      = 1'b0;
    bus.lsu_do_store     = 1'b0;
    bus.lsu_store_data   = '0;
    bus.lsu_store_mask   = '0;
    cache(1'b0, 1'b0, 64'h0, 1'b0);
    step();
    step();
    chk("rst_stall", 64'(bus.lsu_stall_next), 64'h1);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'h0);
    chk("rst_load_data", bus.lsu_load_data, 64'h0);
    chk("rst_fault", 64'(bus.lsu_access_fault), 64'h0);
    chk("rst_req_addr", 64'(bus.mem_req_addr), 64'h0);
    rst = 1'b0;
    step();

    // Load at BASE+4, zero-wait cache
    cache(1'b1, 1'b1, 64'h1122334455667788, 1'b0);
    present(BASE + 4, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    chk("ld_req_valid", 64'(bus.mem_req_valid), 64'h1);
    chk("ld_req_addr", 64'(bus.mem_req_addr), 64'h104);
    chk("ld_req_write", 64'(bus.mem_req_write), 64'h0);
    chk("ld_stall_t1", 64'(bus.lsu_stall_next), 64'h1);
    step();
    chk("ld_stall_t2", 64'(bus.lsu_stall_next), 64'h1);
    chk("ld_wait_no_valid", 64'(bus.mem_req_valid), 64'h0);
    step();
    chk("ld_done_stall", 64'(bus.lsu_stall_next), 64'h0);
    chk("ld_done_data", bus.lsu_load_data, 64'h1122334455667788);
    chk("ld_done_fault", 64'(bus.lsu_access_fault), 64'h0);
    bus.mem_resp_data = 64'hCAFECAFECAFECAFE;
    step();
    chk("ld_idle_stall", 64'(bus.lsu_stall_next), 64'h1);
    step();
    chk("idle_resp_ignored", bus.lsu_load_data, 64'h1122334455667788);

    // Store at BASE, mask 0F
    cache(1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    bus.lsu_store_data = 64'hDEADBEEF;
    bus.lsu_store_mask = 8'h0F;
    present(BASE, 1'b0, 1'b1);
    step();
    bus.lsu_prev_stalled = 1'b1;
    chk("st_req_valid", 64'(bus.mem_req_valid), 64'h1);
    chk("st_req_write", 64'(bus.mem_req_write), 64'h1);
    chk("st_req_wmask", 64'(bus.mem_req_wmask), 64'h0F);
    chk("st_req_wdata", bus.mem_req_wdata, 64'hDEADBEEF);
    step();
    step();
    chk("st_done_stall", 64'(bus.lsu_stall_next), 64'h0);
    chk("st_done_fault", 64'(bus.lsu_access_fault), 64'h0);
    chk("st_done_data", bus.lsu_load_data, 64'h0);
    step();

    // Out-of-range loads at BASE+SIZE and BASE-1
    cache(1'b1, 1'b0, 64'h0, 1'b0);
    present(BASE + 'h40, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    chk("oor_hi_no_req", 64'(bus.mem_req_valid), 64'h0);
    chk("oor_hi_stall", 64'(bus.lsu_stall_next), 64'h0);
    chk("oor_hi_fault", 64'(bus.lsu_access_fault), 64'h1);
    step();
    chk("oor_hi_idle_no_req", 64'(bus.mem_req_valid), 64'h0);
    chk("oor_hi_idle_stall", 64'(bus.lsu_stall_next), 64'h1);
    present(BASE - 1, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    chk("oor_lo_no_req", 64'(bus.mem_req_valid), 64'h0);
    chk("oor_lo_fault", 64'(bus.lsu_access_fault), 64'h1);
    step();

    // Ready held low for 5 REQ cycles, then erroring response; both strobes set
    cache(1'b0, 1'b0, 64'h0, 1'b0);
    present(BASE + 8, 1'b1, 1'b1);
    step();
    bus.lsu_prev_stalled = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_valid", 64'(bus.mem_req_valid), 64'h1);
      chk("bp_req_addr", 64'(bus.mem_req_addr), 64'h108);
      chk("bp_req_write", 64'(bus.mem_req_write), 64'h0);
      step();
    end
    chk("bp_req_valid_last", 64'(bus.mem_req_valid), 64'h1);
    cache(1'b1, 1'b1, 64'h5555AAAA5555AAAA, 1'b1);
    step();
    cache(1'b0, 1'b1, 64'h5555AAAA5555AAAA, 1'b1);
    chk("bp_wait_stall", 64'(bus.lsu_stall_next), 64'h1);
    step();
    chk("bp_done_stall", 64'(bus.lsu_stall_next), 64'h0);
    chk("bp_done_fault", 64'(bus.lsu_access_fault), 64'h1);
    chk("bp_done_data", bus.lsu_load_data, 64'h5555AAAA5555AAAA);
    cache(1'b0, 1'b0, 64'h0, 1'b0);
    step();

    // Back-to-back: top in-range load, then a new request taken in the DONE cycle
    cache(1'b1, 1'b1, 64'h0123456789ABCDEF, 1'b0);
    present(BASE + 'h3F, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    step();
    step();
    chk("b2b_first_done", 64'(bus.lsu_stall_next), 64'h0);
    chk("b2b_first_data", bus.lsu_load_data, 64'h0123456789ABCDEF);
    cache(1'b0, 1'b1, 64'h0, 1'b0);
    present(BASE + 'h10, 1'b0, 1'b0);
    step();
    chk("b2b_req_valid", 64'(bus.mem_req_valid), 64'h1);
    chk("b2b_req_addr", 64'(bus.mem_req_addr), 64'h110);
    chk("b2b_req_write", 64'(bus.mem_req_write), 64'h0);
    bus.lsu_addr = BASE + 'h20;
    step();
    chk("b2b_req_ignores_new", 64'(bus.mem_req_addr), 64'h110);
    chk("b2b_req_stall", 64'(bus.lsu_stall_next), 64'h1);
    bus.lsu_prev_stalled = 1'b1;
    cache(1'b1, 1'b1, 64'hA5A5A5A5A5A5A5A5, 1'b0);
    step();
    step();
    chk("b2b_second_done", 64'(bus.lsu_stall_next), 64'h0);
    chk("b2b_second_data", bus.lsu_load_data, 64'hA5A5A5A5A5A5A5A5);
    step();

    // Reset while in WAIT aborts; later response is ignored
    cache(1'b1, 1'b0, 64'h0, 1'b0);
    present(BASE, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    step();
    chk("rstw_in_wait", 64'(bus.lsu_stall_next), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_stall", 64'(bus.lsu_stall_next), 64'h1);
    chk("rstw_req_valid", 64'(bus.mem_req_valid), 64'h0);
    chk("rstw_load_data", bus.lsu_load_data, 64'h0);
    chk("rstw_req_addr", 64'(bus.mem_req_addr), 64'h0);
    cache(1'b0, 1'b1, 64'h7777777777777777, 1'b0);
    step();
    step();
    chk("rstw_late_stall", 64'(bus.lsu_stall_next), 64'h1);
    chk("rstw_late_data", bus.lsu_load_data, 64'h0);
    cache(1'b0, 1'b0, 64'h0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: no response within 4 WAIT cycles
    cache(1'b1, 1'b0, 64'h0, 1'b0);
    present(BASE, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_wait_stall", 64'(bus.lsu_stall_next), 64'h1);
    end
    step();
    chk("to_done_stall", 64'(bus.lsu_stall_next), 64'h0);
    chk("to_done_fault", 64'(bus.lsu_access_fault), 64'h1);
    chk("to_done_data", bus.lsu_load_data, 64'h0);
    step();
    present(BASE + 8, 1'b1, 1'b0);
    step();
    bus.lsu_prev_stalled = 1'b1;
    step();
    cache(1'b1, 1'b1, 64'hBADBADBADBADBAD0, 1'b1);
    step();
    chk("to_stale_dropped", 64'(bus.lsu_stall_next), 64'h1);
    cache(1'b1, 1'b1, 64'h600D600D600D600D, 1'b0);
    step();
    chk("to_next_done", 64'(bus.lsu_stall_next), 64'h0);
    chk("to_next_data", bus.lsu_load_data, 64'h600D600D600D600D);
    chk("to_next_fault", 64'(bus.lsu_access_fault), 64'h0);
    cache(1'b0, 1'b0, 64'h0, 1'b0);
    step();
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Responder end of the execute-stage LSU port. Accepts one aligned 64-bit load or store per request from the memory execution unit, range-checks it, and forwards it to the data-cache request/response port. It holds `lsu_stall_next` high while busy and drops it for exactly one cycle to deliver load data and the access-fault flag.

## Interface
Parameters:
- `MEM_BASE`, default `'h0`: first valid aligned (8-byte unit) address.
- `MEM_SIZE`, default `'h10000`: number of valid aligned addresses; must be nonzero.
- `TIMEOUT_CYCLES`, default 64: response watchdog limit, used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `lsu_prev_stalled` in 1: low means a request is presented this cycle.
- `lsu_stall_next` out 1: low means the completion cycle.
- `lsu_addr` in `basic_cache_params::aligned_addr_size`: aligned request address.
- `lsu_do_load` in 1: request is a load.
- `lsu_do_store` in 1: request is a store.
- `lsu_store_data` in XLEN: store data.
- `lsu_store_mask` in XLEN/8: byte enables.
- `lsu_load_data` out XLEN: loaded dword; valid in the completion cycle.
- `lsu_access_fault` out 1: access fault; valid in the completion cycle.
- `mem_req_valid` out 1: cache request valid.
- `mem_req_ready` in 1: cache request ready.
- `mem_req_addr` out `aligned_addr_size`: cache request address.
- `mem_req_write` out 1: cache request is a write.
- `mem_req_wdata` out XLEN: cache write data.
- `mem_req_wmask` out XLEN/8: cache write byte enables.
- `mem_resp_valid` in 1: cache response valid.
- `mem_resp_data` in XLEN: cache response data.
- `mem_resp_error` in 1: cache bus error.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- Acceptance:
  - A request is accepted when `lsu_prev_stalled`=0 in IDLE or DONE, which allows back-to-back requests.
  - In REQ and WAIT, `lsu_prev_stalled`=0 is ignored.
  - On acceptance, latch address, data, mask and write=`lsu_do_store`.
- Range check: the address is in range iff `MEM_BASE <= addr < MEM_BASE+MEM_SIZE`. Compare at `aligned_addr_size`+1 bits so the sum cannot wrap.
  - Out of range: go to DONE with fault=1, load_data=0, and issue no cache request.
  - In range: go to REQ.
- REQ: `mem_req_valid`=1 with the latched fields, held stable until `mem_req_ready`. On the handshake, go to WAIT.
- WAIT: on `mem_resp_valid`, capture `mem_resp_data` into load_data (zero for stores) and `mem_resp_error` into fault, then go to DONE.
- DONE: `lsu_stall_next`=0 for one cycle. Next state is REQ/DONE if a new request is accepted, otherwise IDLE.
- `lsu_stall_next` is 1 in every state except DONE.
- `lsu_load_data` and `lsu_access_fault` are registered and change only when entering DONE.
- Stores return fault only; load_data is 0.
- A request with neither `lsu_do_load` nor `lsu_do_store`, or with both, is treated as a load.
- A `mem_resp_valid` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `lsu_stall_next`=1, `mem_req_valid`=0, `lsu_load_data`=0, `lsu_access_fault`=0, `mem_req_*` fields 0.
- `rst` in any state aborts the transaction immediately. The outstanding cache response is then dropped because state is IDLE.
- Out-of-range request accepted at edge T: DONE visible in cycle T+1 (completion latency 1).
- In-range, zero-wait cache: REQ in cycle T+1 with ready=1, WAIT in T+2 with resp_valid=1, DONE in T+3. Minimum latency is 3 cycles.
- Every cycle `mem_req_ready`=0 in REQ, or `mem_resp_valid`=0 in WAIT, adds one cycle.
- `mem_req_ready` and `mem_resp_valid` asserted in the same cycle while in REQ: only the request handshake counts. The response is expected in WAIT.

## Configuration
- Macro: `LSU_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no response, go to DONE with fault=1 and load_data=0.
  - A later stale response must be dropped. Track it with a one-bit `drop_pending` flag, cleared by the next `mem_resp_valid`. While the flag is set, the first `mem_resp_valid` received in WAIT is discarded.
- Undefined: WAIT lasts until a response arrives, with no counter and no flag.

## Structure
- Package `lsu_types`: FSM state enum `lsu_state_e` and the range-check helper width constant.
- Alignment constants come from `basic_cache_params`.
- Sub-module `lsu_watchdog` holds the counter and the stale-drop flag. It is instantiated only under `LSU_TIMEOUT_EN`.

## Test plan
- Load at `MEM_BASE`+4, zero-wait cache returning `'h1122334455667788`: `lsu_stall_next` low exactly in cycle T+3, load_data=`'h1122334455667788`, fault=0.
- Store at `MEM_BASE`, mask `'h0F`, data `'hDEADBEEF`: `mem_req_write`=1, wmask=`'h0F`, wdata=`'hDEADBEEF`. In DONE, fault=0 and load_data=0.
- Load at `MEM_BASE+MEM_SIZE`: no `mem_req_valid` ever, DONE at T+1, fault=1.
- `mem_req_ready` low for 5 cycles, then resp with `mem_resp_error`=1: request fields stable throughout REQ, DONE at T+8, fault=1.
- Back-to-back: a new load presented in a DONE cycle is accepted. The next `mem_req_valid` appears in the following cycle.
- `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no response:
  - DONE after 4 WAIT cycles with fault=1.
  - A late response is dropped.
  - The next load completes with its own data.
  - Variant: `rst` in WAIT returns outputs to reset values.
